// File: rtl/camera_pkg.sv
// Shared definitions for the four-pixel camera controller and its sensor-side responder.
package camera_pkg;

  typedef enum logic [2:0] {
    S_ERASED = 3'd0,
    S_EXPOSE = 3'd1,
    S_HOLD1  = 3'd2,
    S_ROW1   = 3'd3,
    S_HOLD2  = 3'd4,
    S_ROW2   = 3'd5
  } state_t;

  localparam int P11 = 0;
  localparam int P12 = 1;
  localparam int P21 = 2;
  localparam int P22 = 3;

  localparam int PIX_W_DEF = 4;
  localparam int ACC_W_DEF = 8;

  // Controller-side state codes, kept here so both ends agree.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] READOUT = 2'd2;

endpackage

// File: rtl/pixel_acc.sv
// One pixel's saturating photo-current integrator with erase/expose controls.
module pixel_acc
  import camera_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             erase,
  input  logic             expose,
  input  logic [PIX_W-1:0] pix,
  output logic [ACC_W-1:0] acc
);

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - PIX_W){1'b0}}, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       acc <= '0;
    else if (erase)  acc <= '0;
    else if (expose) acc <= sat_add(acc, pix);
  end

endmodule

// File: rtl/pixel_row_reader.sv
// Digital 2x2 pixel array model: integrates on expose, converts the selected row on adc.
module pixel_row_reader
  import camera_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               erase,
  input  logic               expose,
  input  logic               NRE1,
  input  logic               NRE2,
  input  logic               adc,
  input  logic [4*PIX_W-1:0] pix_in,
  output logic [2*ACC_W-1:0] data_out,
  output logic               data_valid,
  output logic               row_id,
  output logic               frame_done,
  output logic               err
);

  logic [ACC_W-1:0] acc [4];
  state_t           state;
  logic             in_row;
  logic             proto_err;

  for (genvar i = 0; i < 4; i++) begin : g_pix
    pixel_acc #(.PIX_W(PIX_W), .ACC_W(ACC_W)) u_acc (
      .clk    (clk),
      .reset  (reset),
      .erase  (erase),
      .expose (expose),
      .pix    (pix_in[i*PIX_W +: PIX_W]),
      .acc    (acc[i])
    );
  end

  always_comb begin
    in_row    = (state == S_ROW1) || (state == S_ROW2);
    proto_err = 1'b0;
    if (!NRE1 && !NRE2)                      proto_err = 1'b1;
    if (adc && !in_row)                      proto_err = 1'b1;
    if ((state == S_HOLD1) && !NRE2)         proto_err = 1'b1;
    if (expose && (!NRE1 || !NRE2))          proto_err = 1'b1;
    if ((state == S_HOLD2) && !NRE1)         proto_err = 1'b1;
    // Erasing once readout has begun throws away a partially read frame.
    if (erase && (in_row || state == S_HOLD2)) proto_err = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_ERASED;
      data_out   <= '0;
      data_valid <= 1'b0;
      row_id     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (proto_err) err <= 1'b1;
      if (erase) begin
        state <= S_ERASED;
      end else begin
        case (state)
          S_ERASED: if (expose) state <= S_EXPOSE;
          S_EXPOSE: if (!expose) state <= S_HOLD1;
          S_HOLD1:  if (!NRE1) state <= S_ROW1;
          S_ROW1: begin
            if (adc) begin
              data_out   <= {acc[P12], acc[P11]};
              row_id     <= 1'b0;
              data_valid <= 1'b1;
            end
            if (NRE1) state <= S_HOLD2;
          end
          S_HOLD2:  if (!NRE2) state <= S_ROW2;
          S_ROW2: begin
            if (adc) begin
              data_out   <= {acc[P22], acc[P21]};
              row_id     <= 1'b1;
              data_valid <= 1'b1;
            end
            if (NRE2) begin
              state      <= S_ERASED;
              frame_done <= 1'b1;
            end
          end
          default:  state <= S_ERASED;
        endcase
      end
    end
  end

endmodule
